clock_monitor: RTL and testbench

//  Receive-side counterpart of the simulation/board clock source. Samples a foreign clock
//  (mon_clk) with the processor clock, synchronises it and emits one-cycle edge strobes.

---
 rtl/clock_monitor.sv | 144 ++++++++++++++
 tb/tb_clock_monitor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_monitor.sv
// Foreign-clock monitor: synchronises mon_clk, emits edge strobes, measures high/low/period
// in clk cycles and flags a clock that has stopped toggling.
module clock_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16,
    parameter int TIMEOUT     = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mon_clk,
    output logic                 rise,
    output logic                 fall,
    output logic [CNT_WIDTH-1:0] high_cycles,
    output logic [CNT_WIDTH-1:0] low_cycles,
    output logic [CNT_WIDTH:0]   period,
    output logic                 valid,
    output logic                 stuck,
    output logic                 stuck_level
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        PRIME,
        HIGH,
        LOW,
        STUCK
    } state_t;

    state_t state, next_state;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   p;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   strobe;
    logic                   timeout;
    logic                   cap_high;
    logic                   cap_low;
    logic                   enter_stuck;
    logic                   leave_stuck;

    assign s       = sync[SYNC_STAGES-1];
    assign strobe  = rise | fall;
    // A strobe in the same cycle as the timeout restarts the count and wins.
    assign timeout = (cnt == CNT_WIDTH'(TIMEOUT)) && !strobe;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= '0;
            p    <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], mon_clk};
            p    <= s;
            rise <= en & s & ~p;
            fall <= en & ~s & p;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (!en) begin
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE:  next_state = ARM;
                ARM:   if (fall) next_state = PRIME; else if (timeout) next_state = STUCK;
                PRIME: if (rise) next_state = HIGH;  else if (timeout) next_state = STUCK;
                HIGH:  if (fall) next_state = LOW;   else if (timeout) next_state = STUCK;
                LOW:   if (rise) next_state = HIGH;  else if (timeout) next_state = STUCK;
                STUCK: if (rise) next_state = HIGH;  else if (fall) next_state = PRIME;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        cap_high    = 1'b0;
        cap_low     = 1'b0;
        enter_stuck = 1'b0;
        leave_stuck = 1'b0;
        if (en) begin
            cap_high    = (state == HIGH) && fall;
            cap_low     = (state == LOW) && rise;
            enter_stuck = (state inside {ARM, PRIME, HIGH, LOW}) && timeout;
            leave_stuck = (state == STUCK) && strobe;
        end else begin
            leave_stuck = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            high_cycles <= '0;
            low_cycles  <= '0;
            period      <= '0;
            valid       <= 1'b0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            if (!en || state == IDLE) begin
                cnt <= '0;
            end else if (strobe) begin
                cnt <= CNT_WIDTH'(1);
            end else if (state != STUCK && cnt != CNT_WIDTH'(TIMEOUT)) begin
                cnt <= cnt + 1'b1;
            end

            if (cap_high) begin
                high_cycles <= cnt;
            end
            if (cap_low) begin
                low_cycles <= cnt;
                period     <= {1'b0, high_cycles} + {1'b0, cnt};
            end

            if (!en || enter_stuck) begin
                valid <= 1'b0;
            end else if (cap_low) begin
                valid <= 1'b1;
            end

            if (enter_stuck) begin
                stuck       <= 1'b1;
                stuck_level <= s;
            end else if (leave_stuck) begin
                stuck <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clock_monitor.sv
// Directed and randomized bench for clock_monitor, checked every cycle against a
// timestamp-based reference model of the monitor's measurement rules.
module tb_clock_monitor;

    localparam int SS = 2;
    localparam int CW = 16;
    localparam int TO = 20;

    localparam int M_IDLE  = 0;
    localparam int M_ARM   = 1;
    localparam int M_PRIME = 2;
    localparam int M_HIGH  = 3;
    localparam int M_LOW   = 4;
    localparam int M_STUCK = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          mon_clk = 1'b0;
    logic          rise, fall, valid, stuck, stuck_level;
    logic [CW-1:0] high_cycles, low_cycles;
    logic [CW:0]   period;

    int errors = 0;
    int checks = 0;

    // Reference model state: mon samples as seen by the first sync flop, newest first.
    bit hist[$];
    int now = 0;
    int anchor = 0;
    int mode = M_IDLE;
    bit m_rise, m_fall, m_valid, m_stuck, m_level;
    int m_high, m_low, m_period;

    clock_monitor #(
        .SYNC_STAGES(SS),
        .CNT_WIDTH  (CW),
        .TIMEOUT    (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mon_clk    (mon_clk),
        .rise       (rise),
        .fall       (fall),
        .high_cycles(high_cycles),
        .low_cycles (low_cycles),
        .period     (period),
        .valid      (valid),
        .stuck      (stuck),
        .stuck_level(stuck_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (t=%0d)", tag, obs, exp, now);
        end
    endtask

    // Advance the model by one clk edge using the inputs sampled at that edge.
    task automatic model_step();
        bit s_prev, p_prev, r_prev, f_prev;
        int cnt_prev;
        now++;
        if (!rst_n) begin
            hist.delete();
            repeat (SS + 1) hist.push_back(1'b0);
            m_rise = 0; m_fall = 0; m_valid = 0; m_stuck = 0; m_level = 0;
            m_high = 0; m_low = 0; m_period = 0;
            mode = M_IDLE;
            anchor = now;
        end else begin
            s_prev   = hist[SS-1];
            p_prev   = hist[SS];
            r_prev   = m_rise;
            f_prev   = m_fall;
            cnt_prev = (now - 1) - anchor;
            m_rise   = en & s_prev & ~p_prev;
            m_fall   = en & ~s_prev & p_prev;
            if (!en) begin
                mode = M_IDLE; m_valid = 0; m_stuck = 0;
            end else if (mode == M_IDLE) begin
                mode = M_ARM; anchor = now;
            end else if (r_prev || f_prev) begin
                anchor = now - 1;
                case (mode)
                    M_ARM:   if (f_prev) mode = M_PRIME;
                    M_PRIME: if (r_prev) mode = M_HIGH;
                    M_HIGH:  if (f_prev) begin m_high = cnt_prev; mode = M_LOW; end
                    M_LOW:   if (r_prev) begin
                                 m_low = cnt_prev; m_period = m_high + cnt_prev;
                                 m_valid = 1; mode = M_HIGH;
                             end
                    M_STUCK: begin mode = r_prev ? M_HIGH : M_PRIME; m_stuck = 0; end
                    default: ;
                endcase
            end else if (mode != M_STUCK && cnt_prev == TO) begin
                mode = M_STUCK; m_stuck = 1; m_level = s_prev; m_valid = 0;
            end
            hist.push_front(mon_clk);
            void'(hist.pop_back());
        end
    endtask

    task automatic compare_all();
        check("rise", rise, m_rise);
        check("fall", fall, m_fall);
        check("high_cycles", high_cycles, m_high);
        check("low_cycles", low_cycles, m_low);
        check("period", period, m_period);
        check("valid", valid, m_valid);
        check("stuck", stuck, m_stuck);
        check("stuck_level", stuck_level, m_level);
    endtask

    task automatic step(input logic r, input logic e, input logic m);
        @(negedge clk);
        rst_n = r; en = e; mon_clk = m;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic run_wave(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            repeat (hi) step(1, 1, 1);
            repeat (lo) step(1, 1, 0);
        end
    endtask

    initial begin
        int lat;
        int width;
        bit lvl;
        repeat (SS + 1) hist.push_back(1'b0);

        // Reset with mon_clk high: the sync ramp rise must not produce a measurement.
        repeat (3) step(0, 1, 1);
        check("reset_valid", valid, 0);
        check("reset_period", period, 0);

        // 8 high / 4 low.
        run_wave(8, 4, 4);
        repeat (4) step(1, 1, 1);
        check("t1_high", high_cycles, 8);
        check("t1_low", low_cycles, 4);
        check("t1_period", period, 12);
        check("t1_valid", valid, 1);

        // Held high: timeout.
        repeat (30) step(1, 1, 1);
        check("t3_stuck", stuck, 1);
        check("t3_level", stuck_level, 1);
        check("t3_valid", valid, 0);

        // Release with a fall, then duty change to 3/9.
        repeat (9) step(1, 1, 0);
        check("t3_unstuck", stuck, 0);
        check("t3_no_valid", valid, 0);
        run_wave(3, 9, 4);
        repeat (4) step(1, 1, 1);
        check("t6_high", high_cycles, 3);
        check("t6_low", low_cycles, 9);
        check("t6_period", period, 12);

        // Drop enable mid-HIGH, then re-enable for a fresh measurement.
        step(1, 1, 1);
        step(1, 0, 1);
        check("t5_valid", valid, 0);
        for (int i = 0; i < 12; i++) step(1, 0, i[1]);
        check("t5_no_rise", rise, 0);
        run_wave(8, 4, 4);
        repeat (4) step(1, 1, 1);
        check("t5_period", period, 12);
        check("t5_valid_again", valid, 1);

        // Strobe latency and width.
        repeat (8) step(1, 1, 0);
        lat = -1; width = 0;
        for (int k = 1; k <= 8; k++) begin
            step(1, 1, 1);
            if (rise === 1'b1) begin
                width++;
                if (lat < 0) lat = k;
            end
        end
        check("t2_rise_latency", lat, SS + 1);
        check("t2_rise_width", width, 1);
        lat = -1; width = 0;
        for (int k = 1; k <= 8; k++) begin
            step(1, 1, 0);
            if (fall === 1'b1) begin
                width++;
                if (lat < 0) lat = k;
            end
        end
        check("t2_fall_latency", lat, SS + 1);
        check("t2_fall_width", width, 1);

        // Reset mid-measurement with mon_clk high, then clean re-measure.
        repeat (3) step(1, 1, 1);
        repeat (2) step(0, 1, 1);
        check("t4_high_cleared", high_cycles, 0);
        check("t4_valid_cleared", valid, 0);
        run_wave(5, 7, 4);
        repeat (4) step(1, 1, 1);
        check("t4_high", high_cycles, 5);
        check("t4_low", low_cycles, 7);

        // Randomized half-periods, occasional enable drops and resets.
        lvl = 1'b1;
        for (int i = 0; i < 80; i++) begin
            int len;
            len = $urandom_range(1, 26);
            if ($urandom_range(0, 14) == 0) begin
                repeat ($urandom_range(1, 4)) step(1, 0, lvl);
            end else if ($urandom_range(0, 24) == 0) begin
                repeat ($urandom_range(1, 3)) step(0, 1, lvl);
            end
            repeat (len) step(1, 1, lvl);
            lvl = ~lvl;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
